// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the 8-bit processor: sequences fetch/decode/execute/memory/write-back,
// with a memory request/ready handshake and timeout, a resumable halt and an illegal/timeout trap.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TIMEOUT_W   = 5
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [1:0] Opcode,
    input  logic [2:0] Funct,
    input  logic       MemReady,
    input  logic       Resume,
    output logic       MemReq,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegOrg1,
    output logic [1:0] RegOrg2,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrc1,
    output logic [1:0] ALUSrc2,
    output logic [1:0] ALUOp,
    output logic [1:0] JumpValue,
    output logic       Cond,
    output logic       Jump,
    output logic       MenWrite,
    output logic       MenRead,
    output logic       MenToReg,
    output logic       Halted,
    output logic       Trap,
    output logic       TrapCause,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6, S_TRAP = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_HALT, C_LW, C_SW, C_JR, C_RST, C_INV, C_BEQZ,
        C_ILL, C_ADD, C_ADDI, C_J, C_BEQR, C_SLT
    } class_t;

    state_t               state_reg;
    class_t               class_reg;
    class_t               dec_class;
    logic [TIMEOUT_W-1:0] wait_cnt_reg;
    logic                 trap_cause_reg;
    logic                 timeout_hit;

    always_comb begin
        dec_class = C_ILL;
        unique case (Opcode)
            2'b00: begin
                unique case (Funct)
                    3'b000: dec_class = C_HALT;
                    3'b001: dec_class = C_LW;
                    3'b010: dec_class = C_SW;
                    3'b011: dec_class = C_JR;
                    3'b100: dec_class = C_RST;
                    3'b101: dec_class = C_INV;
                    3'b110: dec_class = C_BEQZ;
                    default: dec_class = C_ILL;
                endcase
            end
            2'b01: dec_class = C_ADD;
            2'b10: dec_class = Funct[0] ? C_J : C_ADDI;
            default: dec_class = Funct[0] ? C_SLT : C_BEQR;
        endcase
    end

    // Fires on the wait cycle that would bring the count up to MEM_TIMEOUT; a ready in that cycle wins.
    assign timeout_hit = (MEM_TIMEOUT != 0) && !MemReady &&
                         (wait_cnt_reg == TIMEOUT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg      <= S_IDLE;
            class_reg      <= C_NONE;
            wait_cnt_reg   <= '0;
            trap_cause_reg <= 1'b0;
        end else begin
            // The counter only runs while a request is outstanding, so it is zero on entry to FETCH/MEM.
            if ((state_reg == S_FETCH || state_reg == S_MEM) && !MemReady)
                wait_cnt_reg <= wait_cnt_reg + TIMEOUT_W'(1);
            else
                wait_cnt_reg <= '0;

            unique case (state_reg)
                S_IDLE: state_reg <= S_FETCH;
                S_FETCH: begin
                    if (MemReady) begin
                        state_reg <= S_DECODE;
                    end else if (timeout_hit) begin
                        state_reg      <= S_TRAP;
                        trap_cause_reg <= 1'b1;
                    end
                end
                S_DECODE: begin
                    class_reg <= dec_class;
                    unique case (dec_class)
                        C_LW, C_SW:                 state_reg <= S_MEM;
                        C_J, C_JR, C_BEQZ, C_BEQR:  state_reg <= S_WB;
                        C_HALT:                     state_reg <= S_HALT;
                        C_ILL: begin
                            state_reg      <= S_TRAP;
                            trap_cause_reg <= 1'b0;
                        end
                        default:                    state_reg <= S_EXEC;
                    endcase
                end
                S_EXEC: state_reg <= S_WB;
                S_MEM: begin
                    if (MemReady) begin
                        state_reg <= (class_reg == C_SW) ? S_FETCH : S_WB;
                    end else if (timeout_hit) begin
                        state_reg      <= S_TRAP;
                        trap_cause_reg <= 1'b1;
                    end
                end
                S_WB:   state_reg <= S_FETCH;
                S_HALT: if (Resume) state_reg <= S_FETCH;
                default: state_reg <= S_TRAP;
            endcase
        end
    end

    logic in_alu_phase;
    logic in_wb;
    assign in_alu_phase = (state_reg == S_EXEC) || (state_reg == S_WB);
    assign in_wb        = (state_reg == S_WB);

    always_comb begin
        MemReq    = 1'b0;  IRWrite  = 1'b0;  PCWrite  = 1'b0;  RegOrg1  = 1'b0;
        RegOrg2   = 2'b00; RegDst   = 1'b0;  RegWrite = 1'b0;  ALUSrc1  = 1'b0;
        ALUSrc2   = 2'b00; ALUOp    = 2'b00; JumpValue = 2'b00; Cond    = 1'b0;
        Jump      = 1'b0;  MenWrite = 1'b0;  MenRead  = 1'b0;  MenToReg = 1'b0;
        Halted    = 1'b0;  Trap     = 1'b0;
        TrapCause = trap_cause_reg;
        State     = state_reg;

        unique case (state_reg)
            S_FETCH: begin
                MemReq  = 1'b1;
                MenRead = 1'b1;
                IRWrite = MemReady;
            end
            S_MEM: begin
                MemReq = 1'b1;
                if (class_reg == C_SW) begin
                    MenWrite = 1'b1;
                    RegOrg2  = 2'b10;
                    PCWrite  = MemReady;   // sw retires directly from MEM
                end else begin
                    MenRead = 1'b1;
                end
            end
            S_WB:   PCWrite = 1'b1;
            S_HALT: Halted  = 1'b1;
            S_TRAP: Trap    = 1'b1;
            default: ;
        endcase

        // ALU controls set up in EXEC stay stable through WB so the result is written cleanly.
        if (in_alu_phase) begin
            unique case (class_reg)
                C_ADD: begin
                    ALUSrc1 = 1'b1; RegWrite = in_wb;
                end
                C_ADDI: begin
                    RegOrg1 = 1'b1; ALUSrc1 = 1'b1; ALUSrc2 = 2'b01;
                    RegWrite = in_wb; RegDst = in_wb;
                end
                C_SLT: begin
                    RegOrg2 = 2'b01; ALUSrc1 = 1'b1; ALUOp = 2'b11;
                    RegWrite = in_wb; RegDst = in_wb;
                end
                C_INV: begin
                    ALUSrc1 = 1'b1; ALUOp = 2'b01; RegWrite = in_wb;
                end
                C_RST: begin
                    ALUSrc2 = 2'b10; RegWrite = in_wb;
                end
                default: ;
            endcase
        end

        if (in_wb) begin
            unique case (class_reg)
                C_LW: begin
                    RegWrite = 1'b1; RegDst = 1'b1; MenToReg = 1'b1;
                end
                C_J:  Jump = 1'b1;
                C_JR: begin
                    Jump = 1'b1; JumpValue = 2'b01;
                end
                C_BEQZ: begin
                    Jump = 1'b1; Cond = 1'b1; JumpValue = 2'b10;
                    ALUOp = 2'b10; ALUSrc1 = 1'b1; ALUSrc2 = 2'b10;
                end
                C_BEQR: begin
                    Jump = 1'b1; Cond = 1'b1; JumpValue = 2'b10;
                    ALUOp = 2'b10; ALUSrc1 = 1'b1; RegOrg2 = 2'b01;
                end
                default: ;
            endcase
        end
    end

endmodule
